// File: rtl/single_to_int_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : single_to_int_if                                          |
// | Purpose  : stb/ack handshake bundle for the float-to-int converter:  |
// |            one float operand in, one saturating integer result out.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface single_to_int_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_ovf;
  logic        output_z_stb;
  logic        output_z_ack;

  // Converter side
  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_ovf, output_z_stb
  );

  // Producer/consumer side
  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_ovf, output_z_stb
  );
endinterface
`default_nettype wire

// File: rtl/single_to_int.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : single_to_int                                             |
// | Purpose  : IEEE-754 single to signed 32-bit integer, truncating      |
// |            toward zero and saturating out-of-range values.           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module single_to_int #(
  parameter logic [31:0] NAN_VALUE = 32'h80000000
) (
  input  logic             clk,
  input  logic             rst,   // asynchronous, active-low
  single_to_int_if.slave   bus
);

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    UNPACK  = 2'd1,
    CONVERT = 2'd2,
    PUT_Z   = 2'd3
  } state_t;

  localparam logic [31:0] c_NEG_2_31 = 32'hCF000000;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_a, w_a_nxt;
  logic        r_s, w_s_nxt;
  logic [7:0]  r_exp, w_exp_nxt;
  logic [23:0] r_m, w_m_nxt;
  logic        r_ack, w_ack_nxt;
  logic [31:0] r_z, w_z_nxt;
  logic        r_ovf, w_ovf_nxt;
  logic        r_stb, w_stb_nxt;

  logic [31:0] w_mag;
  logic [31:0] w_conv_z;
  logic        w_conv_ovf;

  assign bus.input_a_ack  = r_ack;
  assign bus.output_z     = r_z;
  assign bus.output_z_ovf = r_ovf;
  assign bus.output_z_stb = r_stb;

  // Conversion of the unpacked operand; exponent tests use the biased
  // field directly: e<0 is E<127, e>=31 is E>=158, e>=23 is E>=150.
  always_comb begin
    w_mag      = '0;
    w_conv_z   = '0;
    w_conv_ovf = 1'b0;
    if (r_exp == 8'hFF && r_m[22:0] != 23'd0) begin
      w_conv_z   = NAN_VALUE;
      w_conv_ovf = 1'b1;
    end else if (r_exp < 8'd127) begin
      w_conv_z   = '0;
    end else if (r_exp >= 8'd158) begin
      if (r_a == c_NEG_2_31) begin
        w_conv_z = 32'h80000000;
      end else begin
        w_conv_z   = r_s ? 32'h80000000 : 32'h7FFFFFFF;
        w_conv_ovf = 1'b1;
      end
    end else begin
      if (r_exp >= 8'd150) begin
        w_mag = {8'd0, r_m} << (r_exp - 8'd150);
      end else begin
        w_mag = {8'd0, r_m} >> (8'd150 - r_exp);
      end
      w_conv_z = r_s ? -w_mag : w_mag;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_s_nxt     = r_s;
    w_exp_nxt   = r_exp;
    w_m_nxt     = r_m;
    w_ack_nxt   = r_ack;
    w_z_nxt     = r_z;
    w_ovf_nxt   = r_ovf;
    w_stb_nxt   = r_stb;
    unique case (r_state)
      GET_A: begin
        if (r_ack && bus.input_a_stb) begin
          w_a_nxt     = bus.input_a;
          w_ack_nxt   = 1'b0;
          w_state_nxt = UNPACK;
        end else begin
          w_ack_nxt   = 1'b1;
        end
      end
      UNPACK: begin
        w_s_nxt     = r_a[31];
        w_exp_nxt   = r_a[30:23];
        // Denormals flush to zero, so the hidden bit is only set for E!=0
        w_m_nxt     = (r_a[30:23] == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
        w_state_nxt = CONVERT;
      end
      CONVERT: begin
        w_z_nxt     = w_conv_z;
        w_ovf_nxt   = w_conv_ovf;
        w_stb_nxt   = 1'b1;
        w_state_nxt = PUT_Z;
      end
      PUT_Z: begin
        if (bus.output_z_ack) begin
          // Raising ack on the way back saves a cycle: next accept is one edge later
          w_stb_nxt   = 1'b0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = GET_A;
        end
      end
      default: begin
        w_state_nxt = GET_A;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= GET_A;
      r_a     <= '0;
      r_s     <= 1'b0;
      r_exp   <= '0;
      r_m     <= '0;
      r_ack   <= 1'b0;
      r_z     <= '0;
      r_ovf   <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_s     <= w_s_nxt;
      r_exp   <= w_exp_nxt;
      r_m     <= w_m_nxt;
      r_ack   <= w_ack_nxt;
      r_z     <= w_z_nxt;
      r_ovf   <= w_ovf_nxt;
      r_stb   <= w_stb_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/single_to_int.md
# single_to_int

Converts the IEEE-754 single-precision results of `single_multiplier` into signed 32-bit two's-complement integers. Conversion rounds toward zero and saturates out-of-range values. It sits directly downstream of `single_multiplier`: the multiplier's `output_z`, `output_z_stb` and `output_z_ack` connect to this block's `input_a`, `input_a_stb` and `input_a_ack`. Both interfaces use the same registered stb/ack handshake as the rest of the datapath.

## Interface
- `NAN_VALUE`, default 32'h80000000: integer emitted for any NaN input.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `input_a`  in  32  IEEE-754 single operand.
- `input_a_stb`  in  1  upstream has valid `input_a`.
- `input_a_ack`  out  1  block accepts `input_a`.
- `output_z`  out  32  signed integer result; held stable while `output_z_stb`=1.
- `output_z_ovf`  out  1  result saturated or input was NaN; valid with `output_z_stb`.
- `output_z_stb`  out  1  result valid.
- `output_z_ack`  in  1  downstream consumes result.

## Operation
- FSM states: GET_A, UNPACK, CONVERT, PUT_Z.
- GET_A:
  - Each edge sets `input_a_ack`=1.
  - If `input_a_ack` and `input_a_stb` are both 1 at an edge: latch `input_a`, clear `input_a_ack`, go to UNPACK.
- UNPACK: split into sign s, exponent field E and mantissa m. m = {1, frac} (24 bits). When E=0, m is treated as 0 (denormals flush to zero). Unbiased exponent e = E-127. Go to CONVERT.
- CONVERT: compute the result, register it into `output_z`/`output_z_ovf`, set `output_z_stb`=1, go to PUT_Z. Rules are applied in this order:
  - E=255 and frac≠0 (NaN): `NAN_VALUE`, ovf=1.
  - E=0 or e<0: 0, ovf=0. This covers ±0, denormals and |x|<1.
  - e≥31:
    - If the input is exactly 0xCF000000 (−2^31): 0x80000000, ovf=0.
    - Otherwise: s=0 gives 0x7FFFFFFF and s=1 gives 0x80000000, ovf=1. This includes ±inf.
  - Otherwise: magnitude = m<<(e−23) when e≥23, else m>>(23−e), discarding the shifted-out bits (truncation). Result = s ? −magnitude : magnitude; ovf=0.
- PUT_Z: hold `output_z`, `output_z_ovf` and `output_z_stb`. On an edge with `output_z_ack`=1, clear `output_z_stb` and go to GET_A. Without ack, wait indefinitely.
- Only one operand is in flight. `input_a_ack` is 0 in every state except GET_A.

## Timing
- Reset (`rst`=0, asynchronous): state=GET_A, `input_a_ack`=0, `output_z`=0, `output_z_ovf`=0, `output_z_stb`=0, internal registers cleared.
- First edge after `rst` rises: `input_a_ack` becomes 1. The earliest acceptance is on the second edge.
- Latency: acceptance edge E0 → UNPACK. E1 → CONVERT. At E2, `output_z_stb`=1 with a valid result.
- With `output_z_ack` tied high, throughput is one result per 4 cycles: ack edge E3 → GET_A, `input_a_ack` set at E3, next acceptance at E4.
- `input_a_stb` deasserted during GET_A: no acceptance and no state change. The block ignores `input_a` whenever it is not accepting.
- `output_z_ack` asserted while `output_z_stb`=0: ignored.
- `rst` asserted in any state, including mid-conversion or while holding a result: the in-flight operand is discarded, and all outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset to first accept:
  - Stimulus: hold `rst`=0 for 2 cycles, release, assert `input_a_stb` with `input_a`=0x4144CCCD (12.3).
  - Required: all outputs 0 during reset. `input_a_ack`=1 one edge after release. `output_z`=0x0000000C and ovf=0, with `output_z_stb` at E2.
- Sign and truncation, sent back-to-back with ack tied high:
  - 0xC0FCCCCD (−7.9) → 0xFFFFFFF9.
  - 0x3F7FFFFF (0.99999994) → 0.
  - 0x80000000 (−0) → 0.
  - Results are spaced exactly 4 cycles apart.
- Left-shift path: 0x4B800001 → 0x01000002, ovf=0.
- Saturation and special values:
  - 0x4F000000 → 0x7FFFFFFF, ovf=1.
  - 0xCF000000 → 0x80000000, ovf=0.
  - 0xFF800000 (−inf) → 0x80000000, ovf=1.
  - 0x7FC00000 (NaN) → 0x80000000, ovf=1.
- Backpressure:
  - Stimulus: hold `output_z_ack`=0 for 10 cycles after `output_z_stb`, while driving a new `input_a_stb`.
  - Required: `output_z` stable and `input_a_ack`=0 throughout. After ack, the next operand is accepted 1 edge after return to GET_A.
- Reset mid-operation:
  - Stimulus: assert `rst`=0 while in CONVERT, then release.
  - Required: `output_z_stb` stays 0, and the next operand converts correctly with no stale result emitted.
- Chained with `single_multiplier`: 12.3 × 14.345 (0x4144CCCD, 0x4165851F) → 0x000000B0 (176).
